axi_chan_match_checker: RTL and testbench

// - Synthesizable, single-clock scoreboard that checks an AXI4 path (e.g. a serial link) end to end.
// - Side A is the upstream port; side B is the downstream port. Both ports are snooped, none are driven.
// - AW, W and AR beats taken at A must appear in order, bit-identical, at B.
// - B and R beats taken at B must appear in order, bit-identical, at A.
// - Reports per-channel mismatch pulses, a sticky overflow flag, an error count and a pending flag.

---
 rtl/axi_chan_match_checker_if.sv | 66 ++++++
 rtl/axi_chan_match_checker.sv | 158 +++++++++++++++
 tb/tb_axi_chan_match_checker.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_chan_match_checker_if.sv
// Default AXI channel/struct types plus the snoop interface that bundles one side's req/rsp pair.
// The checker only observes, so it binds through the all-input "mon" modport.
package axi_chan_match_checker_pkg;
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } aw_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    logic    ar_ready;
    r_chan_t r;
    logic    r_valid;
  } rsp_t;
endpackage

interface axi_chan_match_checker_if #(
  parameter type req_t = axi_chan_match_checker_pkg::req_t,
  parameter type rsp_t = axi_chan_match_checker_pkg::rsp_t
);
  req_t req;
  rsp_t rsp;

  modport master (output req, input rsp);
  modport slave  (input req, output rsp);
  modport mon    (input req, input rsp);
endinterface

// File: rtl/axi_chan_match_checker.sv
// End-to-end AXI path scoreboard: per-channel FIFOs hold beats seen at the producer side
// and every beat seen at the consumer side is compared against the oldest stored one.

module axi_chan_match_checker_fifo #(
  parameter type chan_t    = logic,
  parameter int  FifoDepth = 4
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  push,
  input  chan_t push_beat,
  input  logic  pop,
  input  chan_t pop_beat,
  output logic  mismatch,
  output logic  drop,
  output logic  nonempty
);
  localparam int PtrW = $clog2(FifoDepth);
  localparam int CntW = $clog2(FifoDepth + 1);

  chan_t           mem [FifoDepth];
  logic [PtrW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CntW-1:0] count_reg;
  logic            empty, full, bypass, do_push, do_pop;

  always_comb begin
    empty    = (count_reg == '0);
    full     = (count_reg == CntW'(FifoDepth));
    bypass   = push & pop & empty;
    do_pop   = pop & ~empty;
    do_push  = push & ~bypass & (~full | do_pop);
    drop     = push & full & ~do_pop;
    nonempty = ~empty;
    mismatch = 1'b0;
    // Head is read asynchronously: the compare has to happen in the pop cycle.
    if (pop) begin
      if (!empty)    mismatch = (mem[rd_ptr_reg] != pop_beat);
      else if (push) mismatch = (push_beat != pop_beat);
      else           mismatch = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_reg] <= push_beat;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push)
        wr_ptr_reg <= (wr_ptr_reg == PtrW'(FifoDepth - 1)) ? '0 : wr_ptr_reg + 1'b1;
      if (do_pop)
        rd_ptr_reg <= (rd_ptr_reg == PtrW'(FifoDepth - 1)) ? '0 : rd_ptr_reg + 1'b1;
      if (do_push && !do_pop)      count_reg <= count_reg + 1'b1;
      else if (do_pop && !do_push) count_reg <= count_reg - 1'b1;
    end
  end
endmodule

module axi_chan_match_checker #(
  parameter type aw_chan_t = axi_chan_match_checker_pkg::aw_chan_t,
  parameter type w_chan_t  = axi_chan_match_checker_pkg::w_chan_t,
  parameter type b_chan_t  = axi_chan_match_checker_pkg::b_chan_t,
  parameter type ar_chan_t = axi_chan_match_checker_pkg::ar_chan_t,
  parameter type r_chan_t  = axi_chan_match_checker_pkg::r_chan_t,
  parameter type req_t     = axi_chan_match_checker_pkg::req_t,
  parameter type rsp_t     = axi_chan_match_checker_pkg::rsp_t,
  parameter int  FifoDepth = 4,
  parameter int  CntWidth  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  axi_chan_match_checker_if.mon    axi_a,
  axi_chan_match_checker_if.mon    axi_b,
  output logic [4:0]               mismatch_o,
  output logic                     overflow_o,
  output logic [CntWidth-1:0]      err_count_o,
  output logic                     pending_o
);
  req_t a_req, b_req;
  rsp_t a_rsp, b_rsp;

  assign a_req = axi_a.req;
  assign a_rsp = axi_a.rsp;
  assign b_req = axi_b.req;
  assign b_rsp = axi_b.rsp;

  // Bit order {r, ar, b, w, aw}
  logic [4:0] mis_next, drop_evt, nonempty;

  axi_chan_match_checker_fifo #(.chan_t(aw_chan_t), .FifoDepth(FifoDepth)) u_aw (
    .clk_i, .rst_i,
    .push(a_req.aw_valid & a_rsp.aw_ready), .push_beat(a_req.aw),
    .pop (b_req.aw_valid & b_rsp.aw_ready), .pop_beat (b_req.aw),
    .mismatch(mis_next[0]), .drop(drop_evt[0]), .nonempty(nonempty[0]));

  axi_chan_match_checker_fifo #(.chan_t(w_chan_t), .FifoDepth(FifoDepth)) u_w (
    .clk_i, .rst_i,
    .push(a_req.w_valid & a_rsp.w_ready), .push_beat(a_req.w),
    .pop (b_req.w_valid & b_rsp.w_ready), .pop_beat (b_req.w),
    .mismatch(mis_next[1]), .drop(drop_evt[1]), .nonempty(nonempty[1]));

  axi_chan_match_checker_fifo #(.chan_t(b_chan_t), .FifoDepth(FifoDepth)) u_b (
    .clk_i, .rst_i,
    .push(b_rsp.b_valid & b_req.b_ready), .push_beat(b_rsp.b),
    .pop (a_rsp.b_valid & a_req.b_ready), .pop_beat (a_rsp.b),
    .mismatch(mis_next[2]), .drop(drop_evt[2]), .nonempty(nonempty[2]));

  axi_chan_match_checker_fifo #(.chan_t(ar_chan_t), .FifoDepth(FifoDepth)) u_ar (
    .clk_i, .rst_i,
    .push(a_req.ar_valid & a_rsp.ar_ready), .push_beat(a_req.ar),
    .pop (b_req.ar_valid & b_rsp.ar_ready), .pop_beat (b_req.ar),
    .mismatch(mis_next[3]), .drop(drop_evt[3]), .nonempty(nonempty[3]));

  axi_chan_match_checker_fifo #(.chan_t(r_chan_t), .FifoDepth(FifoDepth)) u_r (
    .clk_i, .rst_i,
    .push(b_rsp.r_valid & b_req.r_ready), .push_beat(b_rsp.r),
    .pop (a_rsp.r_valid & a_req.r_ready), .pop_beat (a_rsp.r),
    .mismatch(mis_next[4]), .drop(drop_evt[4]), .nonempty(nonempty[4]));

  assign pending_o = |nonempty;

  // Counter is updated on the same edge that raises mismatch_o, so both stay aligned.
  localparam logic [CntWidth+3:0] ErrMax = {4'b0, {CntWidth{1'b1}}};

  logic [CntWidth-1:0] err_count_reg, err_count_next;
  logic [CntWidth+3:0] err_sum;
  logic [3:0]          err_add;
  logic [4:0]          mismatch_reg;
  logic                overflow_reg;

  always_comb begin
    err_add = 4'd0;
    for (int i = 0; i < 5; i++)
      err_add = err_add + {3'b0, mis_next[i]} + {3'b0, drop_evt[i]};
    err_sum        = {4'b0, err_count_reg} + (CntWidth+4)'(err_add);
    err_count_next = (err_sum > ErrMax) ? {CntWidth{1'b1}} : err_sum[CntWidth-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mismatch_reg  <= '0;
      overflow_reg  <= 1'b0;
      err_count_reg <= '0;
    end else begin
      mismatch_reg  <= mis_next;
      overflow_reg  <= overflow_reg | (|drop_evt);
      err_count_reg <= err_count_next;
    end
  end

  assign mismatch_o  = mismatch_reg;
  assign overflow_o  = overflow_reg;
  assign err_count_o = err_count_reg;
endmodule

// File: tb/tb_axi_chan_match_checker.sv
// Bench for axi_chan_match_checker: table of single-beat transactions plus hand-written
// corner sequences; expected mismatch vectors are queued per edge and checked at negedge.
module tb_axi_chan_match_checker;
  import axi_chan_match_checker_pkg::*;

  localparam int Depth  = 4;
  localparam int CntW   = 3;
  localparam int CH_AW  = 0;
  localparam int CH_W   = 1;
  localparam int CH_B   = 2;
  localparam int CH_AR  = 3;
  localparam int CH_R   = 4;
  localparam int ErrSat = (1 << CntW) - 1;

  logic            clk_i = 1'b0;
  logic            rst_i = 1'b1;
  logic [4:0]      mismatch_o;
  logic            overflow_o;
  logic [CntW-1:0] err_count_o;
  logic            pending_o;

  axi_chan_match_checker_if axi_a_if ();
  axi_chan_match_checker_if axi_b_if ();

  axi_chan_match_checker #(.FifoDepth(Depth), .CntWidth(CntW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .axi_a       (axi_a_if),
    .axi_b       (axi_b_if),
    .mismatch_o  (mismatch_o),
    .overflow_o  (overflow_o),
    .err_count_o (err_count_o),
    .pending_o   (pending_o)
  );

  always #5 clk_i = ~clk_i;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         exp_err = 0;
  logic [4:0] exp_q[$];

  typedef struct {
    int          ch;
    logic [31:0] push_v;
    logic [31:0] pop_v;
    int          gap;
    bit          bad;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = 0x%0h", name, act);
    end
  endtask

  task automatic add_err(input int n);
    exp_err = (exp_err + n > ErrSat) ? ErrSat : exp_err + n;
  endtask

  // Each tick covers one edge; the mismatch vector expected right after it is queued.
  task automatic tick(input logic [4:0] exp_mis);
    @(posedge clk_i);
    exp_q.push_back(exp_mis);
    add_err($countones(exp_mis));
    #1;
  endtask

  always @(negedge clk_i) begin
    if (exp_q.size() > 0) chk("mismatch_o", 32'(mismatch_o), 32'(exp_q.pop_front()));
  end

  function automatic aw_chan_t mk_aw(input logic [31:0] v);
    return '{id: v[3:0] ^ 4'h3, addr: v, len: v[7:0]};
  endfunction
  function automatic w_chan_t mk_w(input logic [31:0] v);
    return '{data: v, strb: v[3:0], last: v[0]};
  endfunction
  function automatic b_chan_t mk_b(input logic [31:0] v);
    return '{id: v[3:0], resp: v[5:4]};
  endfunction
  function automatic ar_chan_t mk_ar(input logic [31:0] v);
    return '{id: v[3:0], addr: v, len: v[11:4]};
  endfunction
  function automatic r_chan_t mk_r(input logic [31:0] v);
    return '{id: v[3:0], data: v, resp: v[5:4], last: v[0]};
  endfunction

  function automatic bit prod_at_a(input int ch);
    return (ch == CH_AW) || (ch == CH_W) || (ch == CH_AR);
  endfunction

  task automatic clear_all();
    axi_a_if.req = '0;
    axi_a_if.rsp = '0;
    axi_b_if.req = '0;
    axi_b_if.rsp = '0;
  endtask

  // Drive a full valid&ready beat on one channel at side A (at_a=1) or side B.
  task automatic set_chan(input int ch, input bit at_a, input logic [31:0] v);
    if (at_a) begin
      case (ch)
        CH_AW: begin axi_a_if.req.aw = mk_aw(v); axi_a_if.req.aw_valid = 1'b1; axi_a_if.rsp.aw_ready = 1'b1; end
        CH_W:  begin axi_a_if.req.w  = mk_w(v);  axi_a_if.req.w_valid  = 1'b1; axi_a_if.rsp.w_ready  = 1'b1; end
        CH_B:  begin axi_a_if.rsp.b  = mk_b(v);  axi_a_if.rsp.b_valid  = 1'b1; axi_a_if.req.b_ready  = 1'b1; end
        CH_AR: begin axi_a_if.req.ar = mk_ar(v); axi_a_if.req.ar_valid = 1'b1; axi_a_if.rsp.ar_ready = 1'b1; end
        default: begin axi_a_if.rsp.r = mk_r(v); axi_a_if.rsp.r_valid = 1'b1; axi_a_if.req.r_ready = 1'b1; end
      endcase
    end else begin
      case (ch)
        CH_AW: begin axi_b_if.req.aw = mk_aw(v); axi_b_if.req.aw_valid = 1'b1; axi_b_if.rsp.aw_ready = 1'b1; end
        CH_W:  begin axi_b_if.req.w  = mk_w(v);  axi_b_if.req.w_valid  = 1'b1; axi_b_if.rsp.w_ready  = 1'b1; end
        CH_B:  begin axi_b_if.rsp.b  = mk_b(v);  axi_b_if.rsp.b_valid  = 1'b1; axi_b_if.req.b_ready  = 1'b1; end
        CH_AR: begin axi_b_if.req.ar = mk_ar(v); axi_b_if.req.ar_valid = 1'b1; axi_b_if.rsp.ar_ready = 1'b1; end
        default: begin axi_b_if.rsp.r = mk_r(v); axi_b_if.rsp.r_valid = 1'b1; axi_b_if.req.r_ready = 1'b1; end
      endcase
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " overflow_o"},  32'(overflow_o),  32'd0);
    chk({tag, " err_count_o"}, 32'(err_count_o), 32'd0);
    chk({tag, " pending_o"},   32'(pending_o),   32'd0);
    chk({tag, " mismatch_o"},  32'(mismatch_o),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit hit, expected $finish earlier");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{ch: CH_AW, push_v: 32'h0000_1000, pop_v: 32'h0000_1000, gap: 5, bad: 1'b0};
    vecs[1] = '{ch: CH_W,  push_v: 32'h0000_00A5, pop_v: 32'h0000_00A4, gap: 0, bad: 1'b1};
    vecs[2] = '{ch: CH_W,  push_v: 32'h1234_5678, pop_v: 32'h1234_5678, gap: 2, bad: 1'b0};
    vecs[3] = '{ch: CH_AR, push_v: 32'hDEAD_0000, pop_v: 32'hDEAD_0000, gap: 1, bad: 1'b0};
    vecs[4] = '{ch: CH_AR, push_v: 32'h0000_0040, pop_v: 32'h0000_0041, gap: 0, bad: 1'b1};
    vecs[5] = '{ch: CH_B,  push_v: 32'h0000_0002, pop_v: 32'h0000_0002, gap: 3, bad: 1'b0};
    vecs[6] = '{ch: CH_B,  push_v: 32'h0000_0001, pop_v: 32'h0000_0003, gap: 0, bad: 1'b1};
    vecs[7] = '{ch: CH_R,  push_v: 32'hCAFE_F00D, pop_v: 32'hCAFE_F00D, gap: 1, bad: 1'b0};
    vecs[8] = '{ch: CH_R,  push_v: 32'h0000_0010, pop_v: 32'h0000_0011, gap: 0, bad: 1'b1};

    clear_all();
    rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
    repeat (20) tick(5'b0);
    chk_idle("reset");

    // Table: push at producer, wait, pop at consumer.
    for (int i = 0; i < 9; i++) begin
      clear_all();
      set_chan(vecs[i].ch, prod_at_a(vecs[i].ch), vecs[i].push_v);
      tick(5'b0);
      clear_all();
      chk($sformatf("v%0d pending after push", i), 32'(pending_o), 32'd1);
      repeat (vecs[i].gap) tick(5'b0);
      set_chan(vecs[i].ch, !prod_at_a(vecs[i].ch), vecs[i].pop_v);
      tick(vecs[i].bad ? 5'(1 << vecs[i].ch) : 5'b0);
      clear_all();
      tick(5'b0);
      chk($sformatf("v%0d pending after pop", i), 32'(pending_o), 32'd0);
      chk($sformatf("v%0d err_count", i), 32'(err_count_o), 32'(exp_err));
    end

    // Unexpected R beat at A.
    set_chan(CH_R, 1'b1, 32'h55);
    tick(5'b10000);
    clear_all();
    tick(5'b0);
    chk("unexpected r err_count", 32'(err_count_o), 32'(exp_err));

    // Valid without ready at B must not pop.
    set_chan(CH_AW, 1'b1, 32'h55);
    tick(5'b0);
    clear_all();
    axi_b_if.req.aw       = mk_aw(32'h99);
    axi_b_if.req.aw_valid = 1'b1;
    tick(5'b0);
    clear_all();
    chk("no handshake pending", 32'(pending_o), 32'd1);
    set_chan(CH_AW, 1'b0, 32'h55);
    tick(5'b0);
    clear_all();
    chk("no handshake drained", 32'(pending_o), 32'd0);

    // Simultaneous push and pop on a non-empty FIFO.
    set_chan(CH_W, 1'b1, 32'h1);
    tick(5'b0);
    set_chan(CH_W, 1'b1, 32'h2);
    set_chan(CH_W, 1'b0, 32'h1);
    tick(5'b0);
    clear_all();
    chk("push+pop pending", 32'(pending_o), 32'd1);
    set_chan(CH_W, 1'b0, 32'h2);
    tick(5'b0);
    clear_all();
    chk("push+pop drained", 32'(pending_o), 32'd0);

    // Bypass on empty FIFO: equal, then unequal.
    set_chan(CH_B, 1'b0, 32'h9);
    set_chan(CH_B, 1'b1, 32'h9);
    tick(5'b0);
    clear_all();
    chk("bypass equal pending", 32'(pending_o), 32'd0);
    set_chan(CH_B, 1'b0, 32'h9);
    set_chan(CH_B, 1'b1, 32'h8);
    tick(5'b00100);
    clear_all();
    chk("bypass unequal pending", 32'(pending_o), 32'd0);

    // Overflow: Depth+1 AR beats at A, then drain Depth at B.
    chk("overflow before", 32'(overflow_o), 32'd0);
    for (int i = 0; i <= Depth; i++) begin
      set_chan(CH_AR, 1'b1, 32'h100 + 32'(i));
      tick(5'b0);
    end
    clear_all();
    add_err(1);
    chk("overflow set", 32'(overflow_o), 32'd1);
    chk("overflow err_count", 32'(err_count_o), 32'(exp_err));
    repeat (3) tick(5'b0);
    chk("overflow sticky", 32'(overflow_o), 32'd1);
    for (int i = 0; i < Depth; i++) begin
      set_chan(CH_AR, 1'b0, 32'h100 + 32'(i));
      tick(5'b0);
    end
    clear_all();
    chk("drain pending", 32'(pending_o), 32'd0);
    chk("drain overflow", 32'(overflow_o), 32'd1);

    // Mid-traffic async reset while a mismatch pulse is high; counter saturated.
    set_chan(CH_AW, 1'b1, 32'h700);
    tick(5'b0);
    set_chan(CH_AW, 1'b1, 32'h701);
    set_chan(CH_R, 1'b1, 32'h77);
    @(posedge clk_i);
    #1;
    clear_all();
    add_err(1);
    chk("pre-reset mismatch_o", 32'(mismatch_o), 32'h10);
    chk("pre-reset err_count saturated", 32'(err_count_o), 32'(exp_err));
    chk("pre-reset pending", 32'(pending_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    chk_idle("async reset");
    exp_err = 0;
    @(posedge clk_i);
    #1 rst_i = 1'b0;
    repeat (3) tick(5'b0);
    chk_idle("after release");

    @(negedge clk_i);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
